ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 101 ++++++++++
 rtl/ps2_event_fifo.sv | 71 +++++++
 rtl/ps2_key_decoder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 key decoder:
//   - parser state encoding (ps2_state_t)
//   - scan-code constants: prefixes, discarded controller bytes, key map
//   - event word layout {extended, break, code[7:0]}
//   - bit indices of the 'held' key-level vector
//   - helper functions: is_prefix, is_discard, key_mask
// -----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_t;

   // Event word layout
   localparam int EVT_W       = 10;
   localparam int EVT_EXT_BIT = 9;
   localparam int EVT_BRK_BIT = 8;
   localparam int EVT_CODE_W  = 8;

   // Prefix bytes
   localparam logic [7:0] SC_EXT_PREFIX = 8'hE0;
   localparam logic [7:0] SC_BRK_PREFIX = 8'hF0;

   // Controller/keyboard housekeeping bytes dropped while idle
   localparam logic [7:0] SC_NULL     = 8'h00;
   localparam logic [7:0] SC_BAT_OK   = 8'hAA;
   localparam logic [7:0] SC_PAUSE    = 8'hE1;
   localparam logic [7:0] SC_ECHO     = 8'hEE;
   localparam logic [7:0] SC_ACK      = 8'hFA;
   localparam logic [7:0] SC_RESEND   = 8'hFE;
   localparam logic [7:0] SC_ERROR    = 8'hFF;

   // Key map: arrow keys arrive with the E0 prefix, WASD/space/enter without
   localparam logic [7:0] SC_UP_ARROW    = 8'h75;
   localparam logic [7:0] SC_DOWN_ARROW  = 8'h72;
   localparam logic [7:0] SC_LEFT_ARROW  = 8'h6B;
   localparam logic [7:0] SC_RIGHT_ARROW = 8'h74;
   localparam logic [7:0] SC_KEY_W       = 8'h1D;
   localparam logic [7:0] SC_KEY_S       = 8'h1B;
   localparam logic [7:0] SC_KEY_A       = 8'h1C;
   localparam logic [7:0] SC_KEY_D       = 8'h23;
   localparam logic [7:0] SC_SPACE       = 8'h29;
   localparam logic [7:0] SC_ENTER       = 8'h5A;

   // held[] bit indices
   localparam int HELD_W     = 6;
   localparam int HELD_UP    = 0;
   localparam int HELD_DOWN  = 1;
   localparam int HELD_LEFT  = 2;
   localparam int HELD_RIGHT = 3;
   localparam int HELD_SPACE = 4;
   localparam int HELD_ENTER = 5;

   function automatic logic is_prefix(input logic [7:0] code);
      return (code == SC_EXT_PREFIX) || (code == SC_BRK_PREFIX);
   endfunction

   function automatic logic is_discard(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      case (code)
         SC_NULL, SC_BAT_OK, SC_PAUSE, SC_ECHO,
         SC_ACK, SC_RESEND, SC_ERROR: hit = 1'b1;
         default:                     hit = 1'b0;
      endcase
      return hit;
   endfunction

   // One-hot held[] mask for a code; the extended flag must match exactly,
   // so E0 1D does not alias onto W and a bare 75 is not the up arrow.
   function automatic logic [HELD_W-1:0] key_mask(input logic ext, input logic [7:0] code);
      logic [HELD_W-1:0] m;
      m = '0;
      if (ext) begin
         case (code)
            SC_UP_ARROW:    m[HELD_UP]    = 1'b1;
            SC_DOWN_ARROW:  m[HELD_DOWN]  = 1'b1;
            SC_LEFT_ARROW:  m[HELD_LEFT]  = 1'b1;
            SC_RIGHT_ARROW: m[HELD_RIGHT] = 1'b1;
            default:        m = '0;
         endcase
      end else begin
         case (code)
            SC_KEY_W: m[HELD_UP]    = 1'b1;
            SC_KEY_S: m[HELD_DOWN]  = 1'b1;
            SC_KEY_A: m[HELD_LEFT]  = 1'b1;
            SC_KEY_D: m[HELD_RIGHT] = 1'b1;
            SC_SPACE: m[HELD_SPACE] = 1'b1;
            SC_ENTER: m[HELD_ENTER] = 1'b1;
            default:  m = '0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// -----------------------------------------------------------------------------
// ps2_event_fifo
// Small synchronous FIFO holding decoded key events.
//   clock    in   system clock
//   resetn   in   asynchronous active-low reset (empties the FIFO)
//   wr_en    in   push request
//   wr_data  in   WIDTH-bit event to push
//   rd_en    in   pop request, ignored while empty
//   rd_data  out  head entry, 0 while empty (combinational from storage)
//   valid    out  FIFO is not empty
//   full     out  FIFO holds DEPTH entries
//   drop     out  one-cycle pulse: a push was refused (full, no pop)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module ps2_event_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid,
   output logic             full,
   output logic             drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_rd;
   logic             do_wr;

   assign valid = (count != '0);
   assign full  = (count == DEPTH_CNT);
   assign do_rd = rd_en && valid;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign do_wr = wr_en && (!full || do_rd);
   assign drop  = wr_en && full && !do_rd;

   assign rd_data = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through rd_data when
   // count says they are live.
   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// -----------------------------------------------------------------------------
// ps2_key_decoder
// Turns the byte stream from a PS/2 controller into make/break events and a
// per-key "held" level vector for six game keys.
//   clock      in   system clock, 50 MHz
//   resetn     in   asynchronous active-low reset
//   rx_data    in   8-bit byte from the PS/2 controller
//   rx_en      in   one-cycle strobe qualifying rx_data
//   evt_data   out  head event {extended, break, code[7:0]}, 0 when empty
//   evt_valid  out  an event is available
//   evt_ready  in   consumer pop
//   held       out  key levels: [0]up [1]down [2]left [3]right [4]space [5]enter
//   overflow   out  sticky: an event was dropped because the FIFO was full
//   dbg_state  out  current parser state (ps2_state_t encoding)
//
// Handshake: an event leaves the FIFO on a rising edge where evt_valid=1 and
// evt_ready=1; evt_ready while evt_valid=0 has no effect, and evt_data/evt_valid
// never depend combinationally on evt_ready.
//
// Optional build macro PS2_KEY_DECODER_TIMEOUT_EN: when defined, a half-received
// prefix (E0 / F0 / E0 F0) is abandoned after TIMEOUT_CYCLES cycles without a
// byte; when undefined the parser waits for the next byte forever.
// -----------------------------------------------------------------------------
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [7:0]        rx_data,
   input  logic              rx_en,
   output logic [EVT_W-1:0]  evt_data,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [HELD_W-1:0] held,
   output logic              overflow,
   output logic [1:0]        dbg_state
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("ps2_key_decoder: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
   end

   ps2_state_t         state;
   ps2_state_t         state_nxt;
   logic               emit;
   logic               evt_ext;
   logic               evt_brk;
   logic [EVT_W-1:0]   evt_word;
   logic               timeout_hit;
   logic [HELD_W-1:0]  key_hit;
   logic [HELD_W-1:0]  held_q;
   logic               overflow_q;
   logic               fifo_drop;
   logic               fifo_full;

   assign dbg_state = state;

   // ---------------------------------------------------------------- parser
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (rx_en) begin
         case (state)
            ST_IDLE: begin
               if (rx_data == SC_EXT_PREFIX)      state_nxt = ST_EXT;
               else if (rx_data == SC_BRK_PREFIX) state_nxt = ST_BRK;
               else                               state_nxt = ST_IDLE;
            end
            ST_EXT: begin
               if (rx_data == SC_BRK_PREFIX)      state_nxt = ST_EXT_BRK;
               else if (rx_data == SC_EXT_PREFIX) state_nxt = ST_EXT;
               else                               state_nxt = ST_IDLE;
            end
            // A second prefix after a break prefix is absorbed in place.
            ST_BRK, ST_EXT_BRK: begin
               if (is_prefix(rx_data))            state_nxt = state;
               else                               state_nxt = ST_IDLE;
            end
            default:                              state_nxt = ST_IDLE;
         endcase
      end else if (timeout_hit) begin
         state_nxt = ST_IDLE;
      end
   end

   always_comb begin
      emit     = 1'b0;
      evt_ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
      evt_brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
      evt_word = '0;
      if (rx_en) begin
         if (state == ST_IDLE) emit = !is_prefix(rx_data) && !is_discard(rx_data);
         else                  emit = !is_prefix(rx_data);
      end
      evt_word[EVT_EXT_BIT]      = evt_ext;
      evt_word[EVT_BRK_BIT]      = evt_brk;
      evt_word[EVT_CODE_W-1:0]   = rx_data;
   end

   // --------------------------------------------------------------- timeout
`ifdef PS2_KEY_DECODER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   // to_cnt counts idle cycles already spent waiting; the edge that would
   // make it TIMEOUT_CYCLES drops the prefix instead.
   assign timeout_hit = !rx_en && (state != ST_IDLE) &&
                        (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                                       to_cnt <= '0;
      else if (rx_en || state == ST_IDLE || timeout_hit) to_cnt <= '0;
      else                                               to_cnt <= to_cnt + TO_W'(1);
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // ------------------------------------------------------------ held levels
   // Updates on every emitted event, even when the FIFO drops it, so key
   // levels stay correct under consumer back-pressure.
   assign key_hit = key_mask(evt_ext, rx_data);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         held_q <= '0;
      end else if (emit) begin
         if (evt_brk) held_q <= held_q & ~key_hit;
         else         held_q <= held_q | key_hit;
      end
   end

   assign held = held_q;

   // ------------------------------------------------------------ event FIFO
   ps2_event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .wr_en   (emit),
      .wr_data (evt_word),
      .rd_en   (evt_ready),
      .rd_data (evt_data),
      .valid   (evt_valid),
      .full    (fifo_full),
      .drop    (fifo_drop)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)        overflow_q <= 1'b0;
      else if (fifo_drop) overflow_q <= 1'b1;
   end

   assign overflow = overflow_q;

   // fifo_full is informational only at this level.
   logic unused_full;
   assign unused_full = fifo_full;

endmodule
